// File: rtl/gamma_seq_pkg.sv
// Shared types and constants for the gamma sequencer.
package gamma_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_FINISH
    } gamma_state_e;

    localparam int GAP_W = 4;

    function automatic int cw_of(input int gamma_cycle_width);
        return $clog2(gamma_cycle_width);
    endfunction

endpackage

// File: rtl/gamma_tick_counter.sv
// CW-bit wrapping tick counter with enable, synchronous clear and terminal-count flag.
module gamma_tick_counter #(
    parameter int CW = 7
) (
    input  logic          aclk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            count_o <= '0;
        end else if (clr_i) begin
            count_o <= '0;
        end else if (en_i) begin
            count_o <= count_o + 1'b1;
        end
    end

    assign tc_o = &count_o;

endmodule

// File: rtl/gamma_seq_ctrl.sv
// Gamma-cycle sequencer: shared counter, grst strobe and registered mem_rst for a cell group.
// Optional GAMMA_SEQ_PAUSE_EN adds a pause input that freezes a RUN interval.
module gamma_seq_ctrl
    import gamma_seq_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 128,
    parameter int CLEAR_CYCLES      = 1,
    parameter int IDX_W             = 16
) (
    input  logic                                 aclk,
    input  logic                                 rst_n,
`ifdef GAMMA_SEQ_PAUSE_EN
    input  logic                                 pause,
`endif
    input  logic                                 start,
    input  logic [IDX_W-1:0]                     num_cycles,
    input  logic                                 stop,
    output logic                                 busy,
    output logic [cw_of(GAMMA_CYCLE_WIDTH)-1:0]  counter,
    output logic                                 grst,
    output logic                                 mem_rst,
    output logic                                 gamma_done,
    output logic [IDX_W-1:0]                     cycle_idx,
    output logic                                 done
);

    localparam int CW = cw_of(GAMMA_CYCLE_WIDTH);
    localparam logic [CW-1:0]    CNT_PRE  = CW'(GAMMA_CYCLE_WIDTH - 2);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(CLEAR_CYCLES - 1);

    gamma_state_e     state_q;
    logic [GAP_W-1:0] gap_q;
    logic             stop_q;
    logic [IDX_W-1:0] num_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             busy_q, grst_q, mrst_q, gdone_q, done_q;
    logic             pause_w, run_adv, tc, last_cycle;

`ifdef GAMMA_SEQ_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    assign run_adv    = (state_q == ST_RUN) && !pause_w;
    assign idx_d      = (&idx_q) ? idx_q : idx_q + 1'b1;
    assign last_cycle = stop_q || stop || ((num_q != '0) && (idx_d == num_q));

    gamma_tick_counter #(.CW(CW)) u_tick (
        .aclk    (aclk),
        .rst_n   (rst_n),
        .clr_i   (state_q != ST_RUN),
        .en_i    (run_adv),
        .count_o (counter),
        .tc_o    (tc)
    );

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            stop_q  <= 1'b0;
            num_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            grst_q  <= 1'b0;
            mrst_q  <= 1'b1;
            gdone_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            grst_q  <= 1'b0;
            gdone_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_q   <= num_cycles;
                        idx_q   <= '0;
                        stop_q  <= stop;
                        gap_q   <= GAP_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (stop) stop_q <= 1'b1;
                    if (gap_q == '0) begin
                        state_q <= ST_RUN;
                        mrst_q  <= 1'b0;
                        grst_q  <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) stop_q <= 1'b1;
                    // A paused RUN holds everything; strobes stay low until counting resumes.
                    if (run_adv) begin
                        if (tc) begin
                            idx_q  <= idx_d;
                            mrst_q <= 1'b1;
                            if (last_cycle) begin
                                state_q <= ST_FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_CLEAR;
                                gap_q   <= GAP_INIT;
                            end
                        end else if (counter == CNT_PRE) begin
                            gdone_q <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    stop_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign grst       = grst_q;
    assign mem_rst    = mrst_q;
    assign gamma_done = gdone_q;
    assign cycle_idx  = idx_q;
    assign done       = done_q;

endmodule
